// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: scan bundle between the VGA timing generator and its consumers.
//   pixel_x, pixel_y        - current column / row counters
//   line_start, frame_start - undelayed pulses at column 0 / at (0,0)
//   video_on, hsync, vsync  - delayed visible flag and sync levels for the DAC
// master: the timing generator drives every signal.
// slave:  renderers and the connector only read them.
interface vga_timing_gen_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;
    logic       video_on;
    logic       hsync;
    logic       vsync;

    modport master (
        output pixel_x, pixel_y, line_start, frame_start, video_on, hsync, vsync
    );

    modport slave (
        input pixel_x, pixel_y, line_start, frame_start, video_on, hsync, vsync
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA scan generator running on the pixel clock.
// Ports:
//   clk_0 - pixel clock (25 MHz)
//   rst   - synchronous, active-high reset
//   vga   - master side of vga_timing_gen_if:
//           pixel_x/pixel_y counters, line_start/frame_start pulses (undelayed),
//           video_on/hsync/vsync delayed by PIPE_DELAY cycles
// PIPE_DELAY must lie in 1..8; counters are 10 bits wide, so both totals must be <= 1024.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0,
    parameter int unsigned PIPE_DELAY  = 1
) (
    input  logic             clk_0,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       x_wrap;

    logic       vis_raw, hs_raw, vs_raw;

    logic [PIPE_DELAY-1:0] vis_pipe_q, vis_pipe_d;
    logic [PIPE_DELAY-1:0] hs_pipe_q,  hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q,  vs_pipe_d;

    // Counter next state: x wraps every line, y steps only on the x wrap.
    always_comb begin
        x_wrap = (x_q == 10'(H_TOTAL - 1));
        x_d    = x_wrap ? 10'd0 : x_q + 10'd1;
        y_d    = y_q;
        if (x_wrap) begin
            y_d = (y_q == 10'(V_TOTAL - 1)) ? 10'd0 : y_q + 10'd1;
        end
    end

    // Raw decodes straight off the counter registers.
    always_comb begin
        vis_raw = (x_q < 10'(H_VISIBLE)) && (y_q < 10'(V_VISIBLE));
        hs_raw  = (x_q >= 10'(HS_START)) && (x_q < 10'(HS_END));
        vs_raw  = (y_q >= 10'(VS_START)) && (y_q < 10'(VS_END));
    end

    // Shift registers: bit 0 takes the raw decode, bit PIPE_DELAY-1 is the output tap.
    always_comb begin
        vis_pipe_d    = vis_pipe_q << 1;
        vis_pipe_d[0] = vis_raw;
        hs_pipe_d     = hs_pipe_q << 1;
        hs_pipe_d[0]  = hs_raw;
        vs_pipe_d     = vs_pipe_q << 1;
        vs_pipe_d[0]  = vs_raw;
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            vis_pipe_q <= '0;
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            vis_pipe_q <= vis_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
        end
    end

    // Pulses are undelayed so consumers can align on the same edge they sample the counters.
    always_comb begin
        vga.pixel_x     = x_q;
        vga.pixel_y     = y_q;
        vga.line_start  = (x_q == 10'd0);
        vga.frame_start = (x_q == 10'd0) && (y_q == 10'd0);
        vga.video_on    = vis_pipe_q[PIPE_DELAY-1];
        vga.hsync       = hs_pipe_q[PIPE_DELAY-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vga.vsync       = vs_pipe_q[PIPE_DELAY-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Produces the 640x480 @ 60 Hz VGA scan for the Pong console. Runs on the 25 MHz pixel clock `clk_0`. Drives the `pixel_x`/`pixel_y` coordinate stream that every overlay and renderer consumes (text strings, paddles, ball), plus the `hsync`/`vsync`/`video_on` signals sent to the DAC/connector. The sync outputs pass through a configurable delay line, so they stay aligned with renderers that register their pixel decisions.

## Interface

Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_ACTIVE`, 0, asserted level of `hsync`/`vsync`
- `PIPE_DELAY`, 1, cycles of delay on `hsync`/`vsync`/`video_on`, legal range 1..8

Ports:
- `clk_0`  input  1  pixel clock, 25 MHz
- `rst`  input  1  synchronous, active-high reset
- `pixel_x`  output  10  current column counter, 0..H_TOTAL-1
- `pixel_y`  output  10  current row counter, 0..V_TOTAL-1
- `line_start`  output  1  one-cycle pulse while `pixel_x`==0
- `frame_start`  output  1  one-cycle pulse while `pixel_x`==0 and `pixel_y`==0
- `video_on`  output  1  visible-area flag, delayed by PIPE_DELAY
- `hsync`  output  1  horizontal sync, delayed by PIPE_DELAY
- `vsync`  output  1  vertical sync, delayed by PIPE_DELAY

## Operation

Derived totals:
- H_TOTAL = sum of the H parameters (800)
- V_TOTAL = sum of the V parameters (525)

Counters:
- `pixel_x` and `pixel_y` are registers (not decoded values).
- `pixel_x` increments every cycle. At H_TOTAL-1 it wraps to 0.
- `pixel_y` increments only on the cycle where `pixel_x` wraps.
- At `pixel_y`==V_TOTAL-1, a `pixel_x` wrap takes `pixel_y` to 0 (frame wrap).
- No other counter states exist. Values ≥ total are unreachable.

Raw decodes (combinational from the counter registers):
- vis_raw = (`pixel_x` < H_VISIBLE) && (`pixel_y` < V_VISIBLE)
- hs_raw is asserted when H_VISIBLE+H_FRONT ≤ `pixel_x` < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- vs_raw is asserted when V_VISIBLE+V_FRONT ≤ `pixel_y` < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491. It is line-based, independent of `pixel_x`.
- `line_start` and `frame_start` are combinational from the counters. They are not delayed.

Delay line:
- vis_raw, hs_raw and vs_raw each pass through a PIPE_DELAY-stage shift register.
- Output = stage PIPE_DELAY-1.
- `hsync` = SYNC_ACTIVE when the delayed hs is set, else ~SYNC_ACTIVE. `vsync` follows the same rule.
- Purpose: a renderer that samples `pixel_x`/`pixel_y` and registers its colour N times uses PIPE_DELAY=N. Default 1 matches single-register text/sprite overlays.

Reset:
- `pixel_x`=0, `pixel_y`=0.
- Every delay-line stage is cleared to vis=0 / hs=0 / vs=0.
- Outputs while `rst` is high: `video_on`=0, `hsync`=`vsync`=~SYNC_ACTIVE, `line_start`=1, `frame_start`=1 (counters sit at 0,0).
- Reset asserted mid-frame takes effect on the next edge: counters go to 0,0 and all delayed outputs go inactive, whatever they held before.

## Timing

- First cycle after `rst` falls: `pixel_x`=0, `pixel_y`=0, `frame_start`=1.
- The counters advance from that edge onward.
- `video_on` rises PIPE_DELAY cycles after (0,0) is presented.
- Line period: exactly 800 cycles. Frame period: exactly 420000 cycles.
- `hsync`:
  - Asserted for exactly 96 consecutive cycles per line.
  - First asserted cycle is PIPE_DELAY cycles after `pixel_x` first reads 656.
  - Asserted on every line, including vertical blanking lines.
- `vsync`:
  - Asserted for exactly 1600 consecutive cycles (2 lines).
  - First asserted cycle is PIPE_DELAY cycles after (`pixel_x`,`pixel_y`)=(0,490).
- `video_on`: high for exactly 307200 cycles per frame, in 480 runs of 640.
- Wrap cycle (799,524)→(0,0): `line_start` and `frame_start` both rise. `vsync` is not asserted there.
- The delay-line outputs reproduce the raw sequence shifted by PIPE_DELAY with no glitch at any wrap.

## Test plan

- Reset hold 10 cycles, release:
  - during reset: `video_on`=0, `hsync`=`vsync`=1, x=y=0
  - after release: x counts 0,1,2,…; `video_on`=1 on cycle 1 (PIPE_DELAY=1)
- One full line:
  - `pixel_x` 0→799→0
  - `pixel_y` increments once, on the wrap
  - `hsync` low for 96 cycles starting the cycle after x=656
  - `line_start` pulses once
- Two full frames:
  - `frame_start` pulses exactly 420000 cycles apart
  - `video_on` high count = 307200 per frame
  - `vsync` low for 1600 consecutive cycles starting the cycle after (0,490)
- Reset asserted at (400,300) with `video_on`=1:
  - next edge gives x=y=0, `video_on`=0, `hsync`=`vsync`=1
  - after release, the frame timing restarts from (0,0)
- PIPE_DELAY=3, SYNC_ACTIVE=1:
  - `hsync` high 96 cycles starting 3 cycles after x=656
  - `video_on` rises 3 cycles after (0,0)
  - a one-register overlay plus two extra registers on the colour path lines up edge-for-edge with `video_on`
